// File: rtl/aes_pkg.sv
// Shared AES definitions for the round-datapath blocks: byte layout, FSM encodings,
// GF(2^8) arithmetic used by the S-box lanes, and the legal-lane check.
package aes_pkg;

    localparam int AES_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte 0 sits in the most significant position of the 128-bit state.
    function automatic logic [7:0] byte_at(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

// File: rtl/Inv_S_box.sv
// Inverse AES S-box: inverse affine transform followed by GF(2^8) inversion.
module Inv_S_box
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);

    logic [7:0] pre;

    assign pre    = rotl8(value, 1) ^ rotl8(value, 3) ^ rotl8(value, 6) ^ 8'h05;
    assign result = gf_inv(pre);

endmodule

// File: rtl/S_box.sv
// Forward AES S-box: GF(2^8) inversion followed by the affine transform.
module S_box
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);

    logic [7:0] inv;

    assign inv    = gf_inv(value);
    assign result = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes over 16/LANES beats with valid/ready on both sides.
// Define SUB_BYTES_INV_EN to add the MODE port and inverse S-box lanes.
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = 128,
    parameter int LANES        = 4
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [BLOCK_LENGTH-1:0] IN,
`ifdef SUB_BYTES_INV_EN
    input  logic                    MODE,
`endif
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [BLOCK_LENGTH-1:0] OUT
);

    localparam int NBEATS = AES_BYTES / LANES;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if (BLOCK_LENGTH != 128 || !lanes_legal(LANES)) begin : g_bad_cfg
        $error("sub_bytes_seq: BLOCK_LENGTH must be 128 and LANES one of 1,2,4,8,16");
    end

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [BLOCK_LENGTH-1:0] data;
    logic [7:0]              lane_in  [LANES];
    logic [7:0]              lane_out [LANES];
    logic                    accept;
`ifdef SUB_BYTES_INV_EN
    logic                    mode_r;
`endif

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_in[j] = byte_at(data, int'(cnt) * LANES + j);
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [7:0] fwd;
        S_box u_sbox (.value(lane_in[j]), .result(fwd));
`ifdef SUB_BYTES_INV_EN
        logic [7:0] rev;
        Inv_S_box u_inv_sbox (.value(lane_in[j]), .result(rev));
        assign lane_out[j] = mode_r ? rev : fwd;
`else
        assign lane_out[j] = fwd;
`endif
    end

    // A finished state can hand off and take the next one on the same edge.
    assign IN_READY  = (state == IDLE) || ((state == DONE) && OUT_READY);
    assign accept    = IN_VALID && IN_READY;
    assign OUT_VALID = (state == DONE);
    assign OUT       = data;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= IDLE;
            cnt   <= '0;
            data  <= '0;
`ifdef SUB_BYTES_INV_EN
            mode_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    cnt <= '0;
                    if (accept) begin
                        data  <= IN;
`ifdef SUB_BYTES_INV_EN
                        mode_r <= MODE;
`endif
                        state <= BUSY;
                    end else if (state == DONE && OUT_READY) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    for (int j = 0; j < LANES; j++) begin
                        data[BLOCK_LENGTH-1-8*(int'(cnt)*LANES+j) -: 8] <= lane_out[j];
                    end
                    if (cnt == CNT_W'(NBEATS - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
